serial_addsub: RTL and testbench

//   Parametrised digit-serial adder/subtractor. It is the sequential successor
//   to the combinational full adder: a single DIGIT-bit adder slice plus a

---
 rtl/serial_addsub_if.sv | 44 ++++
 rtl/serial_addsub.sv | 146 ++++++++++++++
 tb/tb_serial_addsub.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if
//   Request/result bundle for the digit-serial adder/subtractor.
//
//   Handshake: a request is accepted on a rising edge where start=1 and busy=0.
//   A, B, Cin and sub are captured on that edge only. busy stays high while the
//   operation runs. done pulses for one cycle when sum/Cout/ovf have just been
//   updated. Those three outputs then hold until the next done pulse or reset.
//
//   Signals
//     start  requester -> unit   request, sampled only while busy=0
//     A, B   requester -> unit   WIDTH-bit operands
//     Cin    requester -> unit   carry-in (add) / borrow-in (sub)
//     sub    requester -> unit   0: A+B+Cin, 1: A-B-Cin
//     busy   unit -> requester   operation in progress
//     done   unit -> requester   one-cycle completion pulse
//     sum    unit -> requester   WIDTH-bit result
//     Cout   unit -> requester   raw carry out (sub: 1 = no borrow)
//     ovf    unit -> requester   two's-complement signed overflow
// -----------------------------------------------------------------------------
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, A, B, Cin, sub,
    input  busy, done, sum, Cout, ovf
  );

  modport slave (
    input  start, A, B, Cin, sub,
    output busy, done, sum, Cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Digit-serial adder/subtractor. One DIGIT-bit adder slice plus a carry
//   flip-flop is reused over N = WIDTH/DIGIT cycles to form A+B+Cin or
//   A-B-Cin on WIDTH-bit operands.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous reset, active-high
//     bus      --   serial_addsub_if.slave (start/A/B/Cin/sub in,
//                   busy/done/sum/Cout/ovf out)
//     o_state  out  current FSM state (0 = IDLE, 1 = RUN) for observation
//
//   Timing: accept edge T0 -> busy=1; completion edge T0+N -> done=1,
//   sum/Cout/ovf updated, busy=0.
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_addsub_if.slave     bus,
  output logic               o_state
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_digit;
  logic [DIGIT-1:0] w_d;
  logic             w_c;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_a_next;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == LAST);

  // Single DIGIT-bit adder slice.
  assign w_digit = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
  assign w_d     = w_digit[DIGIT-1:0];
  assign w_c     = w_digit[DIGIT];

  // Carry into the top bit of the current digit: sum bit = a ^ b ^ cin, so
  // cin = a ^ b ^ sum. On the last digit this is the carry into the MSB.
  assign w_c_msb_in = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1] ^ w_d[DIGIT-1];

  // Result digits shift into the MSB end of a_sh as its operand digits are
  // consumed from the LSB end, so a_sh doubles as the result shift register.
  // After the last digit the full result is {w_d, a_sh[WIDTH-1:DIGIT]}.
  generate
    if (DIGIT < WIDTH) begin : g_multi_digit
      assign w_a_next = {w_d, r_a_sh[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
      assign w_a_next = w_d;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM / result outputs
  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = r_done;
    bus.sum  = r_sum;
    bus.Cout = r_cout;
    bus.ovf  = r_ovf;
    o_state  = r_state;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Subtraction is A + ~B + 1 - Cin, i.e. carry-in = ~Cin.
        r_a_sh  <= bus.A;
        r_b_sh  <= bus.sub ? ~bus.B : bus.B;
        r_carry <= bus.Cin ^ bus.sub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh  <= w_a_next;
        r_b_sh  <= r_b_sh >> DIGIT;
        r_carry <= w_c;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_sum  <= w_a_next;
          r_cout <= w_c;
          r_ovf  <= w_c ^ w_c_msb_in;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Bench for serial_addsub. dut1 is WIDTH=8/DIGIT=1, dut4 is WIDTH=8/DIGIT=4.
//   Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();
  logic st1, st4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if1.slave),
    .o_state (st1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if4.slave),
    .o_state (st4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {Cout, ovf, sum}
  logic [9:0] exp_q[$];

  // Reference arithmetic, written from the definition of A+B+Cin / A-B-Cin.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sb);
    logic [8:0] r;
    logic       ov;
    if (!sb) begin
      r  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      ov = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r  = {1'b0, a} + {1'b0, ~b} + {8'b0, ~cin};
      ov = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {r[8], ov, r[7:0]};
  endfunction

  // ---------------- driver ----------------
  // Issues one request to dut1 (use4=0) or dut4 (use4=1) and waits (bounded)
  // for done. lat is the number of edges after the accept edge; -1 on timeout.
  task automatic run_op(input bit use4, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat);
    @(negedge clk);
    if (use4) begin
      if4.A = a; if4.B = b; if4.Cin = cin; if4.sub = sb; if4.start = 1'b1;
    end else begin
      if1.A = a; if1.B = b; if1.Cin = cin; if1.sub = sb; if1.start = 1'b1;
    end
    @(posedge clk); #1;
    if1.start = 1'b0;
    if4.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((use4 ? if4.done : if1.done) === 1'b1) begin
        lat = i;
        break;
      end
    end
    s  = use4 ? if4.sum  : if1.sum;
    co = use4 ? if4.Cout : if1.Cout;
    ov = use4 ? if4.ovf  : if1.ovf;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (if1.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got %b exp 0", if1.busy); end
    n_checks++; if (if1.done !== 1'b0) begin n_errors++; $display("FAIL rst_done got %b exp 0", if1.done); end
    n_checks++; if (if1.sum !== 8'h00) begin n_errors++; $display("FAIL rst_sum got %h exp 00", if1.sum); end
    n_checks++; if ({if1.Cout, if1.ovf} !== 2'b00) begin n_errors++; $display("FAIL rst_cout_ovf got %b exp 00", {if1.Cout, if1.ovf}); end
    n_checks++; if (st1 !== 1'b0) begin n_errors++; $display("FAIL rst_state got %b exp 0", st1); end
    n_checks++; if (if4.sum !== 8'h00) begin n_errors++; $display("FAIL rst_sum4 got %h exp 00", if4.sum); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] s; logic co, ov; int lat;
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (lat != 8) begin n_errors++; $display("FAIL add_latency got %0d exp 8", lat); end
    n_checks++; if ({co, ov, s} !== {1'b0, 1'b0, 8'h10}) begin n_errors++; $display("FAIL add_0f_01 got %b%b_%h exp 00_10", co, ov, s); end
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if ({co, ov, s} !== {1'b1, 1'b0, 8'h00}) begin n_errors++; $display("FAIL add_wrap got %b%b_%h exp 10_00", co, ov, s); end
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if ({co, ov, s} !== {1'b0, 1'b1, 8'h80}) begin n_errors++; $display("FAIL add_ovf got %b%b_%h exp 01_80", co, ov, s); end
    // Cin contributes: 0x20 + 0x30 + 1
    run_op(1'b0, 8'h20, 8'h30, 1'b1, 1'b0, s, co, ov, lat);
    n_checks++; if ({co, ov, s} !== {1'b0, 1'b0, 8'h51}) begin n_errors++; $display("FAIL add_cin got %b%b_%h exp 00_51", co, ov, s); end
  endtask

  task automatic test_sub();
    logic [7:0] s; logic co, ov; int lat;
    logic [7:0] ta[3]; logic [7:0] tb_[3]; logic tc[3];
    logic [9:0] te[3];
    ta[0] = 8'h05; tb_[0] = 8'h07; tc[0] = 1'b0; te[0] = {1'b0, 1'b0, 8'hFE};
    ta[1] = 8'h80; tb_[1] = 8'h01; tc[1] = 1'b0; te[1] = {1'b1, 1'b1, 8'h7F};
    ta[2] = 8'h10; tb_[2] = 8'h01; tc[2] = 1'b1; te[2] = {1'b1, 1'b0, 8'h0E};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ta[i], tb_[i], tc[i], 1'b1, s, co, ov, lat);
      n_checks++;
      if ({co, ov, s} !== te[i]) begin
        n_errors++;
        $display("FAIL sub_vec%0d got %b%b_%h exp %b%b_%h", i, co, ov, s, te[i][9], te[i][8], te[i][7:0]);
      end
    end
  endtask

  // start held high with operands changing every cycle. A request is accepted
  // on the edge after each done (busy=0 in the done cycle), so done pulses
  // repeat every N+1 = 9 edges and each result belongs to the operands that
  // were present 8 edges before its done.
  task automatic test_back_to_back();
    logic [7:0] ha[0:63]; logic [7:0] hb[0:63]; logic hc[0:63]; logic hs[0:63];
    logic [7:0] prev_sum;
    logic [9:0] e_v;
    int last_done;
    int n_done;
    prev_sum  = if1.sum;
    last_done = -1;
    n_done    = 0;
    for (int e = 0; e <= 44; e++) begin
      @(negedge clk);
      ha[e] = 8'(e * 37 + 11);
      hb[e] = 8'(e * 53 + 5);
      hc[e] = e[0];
      hs[e] = e[1];
      if1.A = ha[e]; if1.B = hb[e]; if1.Cin = hc[e]; if1.sub = hs[e];
      if1.start = 1'b1;
      @(posedge clk); #1;
      if (if1.done === 1'b1) begin
        n_done++;
        n_checks++;
        if (e < 8) begin
          n_errors++;
          $display("FAIL b2b_early_done got edge %0d exp >=8", e);
        end else begin
          e_v = model(ha[e-8], hb[e-8], hc[e-8], hs[e-8]);
          if ({if1.Cout, if1.ovf, if1.sum} !== e_v) begin
            n_errors++;
            $display("FAIL b2b_result edge %0d got %b%b_%h exp %b%b_%h", e, if1.Cout, if1.ovf, if1.sum, e_v[9], e_v[8], e_v[7:0]);
          end
        end
        if (last_done >= 0) begin
          n_checks++;
          if (e - last_done != 9) begin n_errors++; $display("FAIL b2b_period got %0d exp 9", e - last_done); end
        end
        last_done = e;
        prev_sum  = if1.sum;
      end else begin
        n_checks++;
        if (if1.sum !== prev_sum) begin n_errors++; $display("FAIL b2b_hold edge %0d got %h exp %h", e, if1.sum, prev_sum); end
      end
    end
    @(negedge clk);
    if1.start = 1'b0;
    n_checks++; if (n_done != 5) begin n_errors++; $display("FAIL b2b_count got %0d exp 5", n_done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic co, ov; int lat; int seen;
    // leave a nonzero result in place first
    run_op(1'b0, 8'h33, 8'h22, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (s !== 8'h55) begin n_errors++; $display("FAIL rmid_pre got %h exp 55", s); end
    @(negedge clk);
    if1.A = 8'h0F; if1.B = 8'h01; if1.Cin = 1'b0; if1.sub = 1'b0; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (if1.busy !== 1'b1) begin n_errors++; $display("FAIL rmid_busy_before got %b exp 1", if1.busy); end
    n_checks++; if (if1.sum !== 8'h55) begin n_errors++; $display("FAIL rmid_hold_in_run got %h exp 55", if1.sum); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (if1.busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got %b exp 0", if1.busy); end
    n_checks++; if (if1.sum !== 8'h00) begin n_errors++; $display("FAIL rmid_sum got %h exp 00", if1.sum); end
    n_checks++; if ({if1.done, if1.Cout, if1.ovf} !== 3'b000) begin n_errors++; $display("FAIL rmid_flags got %b exp 000", {if1.done, if1.Cout, if1.ovf}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if1.done === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rmid_no_done got %0d exp 0", seen); end
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (lat != 8 || s !== 8'h10) begin n_errors++; $display("FAIL rmid_after got lat %0d sum %h exp lat 8 sum 10", lat, s); end
  endtask

  task automatic test_digit4();
    logic [7:0] s; logic co, ov; int lat;
    logic [7:0] a, b; logic cin, sb;
    logic [9:0] e_v;
    run_op(1'b1, 8'h9C, 8'h68, 1'b1, 1'b0, s, co, ov, lat);
    n_checks++; if (lat != 2) begin n_errors++; $display("FAIL d4_latency got %0d exp 2", lat); end
    n_checks++; if ({co, ov, s} !== {1'b1, 1'b0, 8'h05}) begin n_errors++; $display("FAIL d4_vec got %b%b_%h exp 10_05", co, ov, s); end
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      sb  = 1'($urandom_range(0, 1));
      exp_q.push_back(model(a, b, cin, sb));
      run_op(i >= 30 ? 1'b0 : 1'b1, a, b, cin, sb, s, co, ov, lat);
      e_v = exp_q.pop_front();
      n_checks++;
      if ({co, ov, s} !== e_v || lat != (i >= 30 ? 8 : 2)) begin
        n_errors++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got %b%b_%h lat %0d exp %b%b_%h", i, a, b, cin, sb, co, ov, s, lat, e_v[9], e_v[8], e_v[7:0]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    if1.start = 1'b0; if1.A = '0; if1.B = '0; if1.Cin = 1'b0; if1.sub = 1'b0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.Cin = 1'b0; if4.sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_digit4();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
